// File: rtl/button_event_decoder_if.sv
// Button event decoder bus: debounced button level in, gesture pulses,
// status flags and event counter out.
interface button_event_decoder_if;
  logic       btn_in;
  logic       short_press;
  logic       long_press;
  logic       double_press;
  logic       holding;
  logic       busy;
  logic [7:0] event_count;

  // Producer of the button level / consumer of the gesture events
  modport master (
    output btn_in,
    input  short_press, long_press, double_press, holding, busy, event_count
  );

  // The decoder itself
  modport slave (
    input  btn_in,
    output short_press, long_press, double_press, holding, busy, event_count
  );
endinterface

// File: rtl/button_event_decoder.sv
// Button gesture classifier: turns a clean button level into one-cycle
// short / long / double press pulses and keeps a wrapping event count.
// Every output is a flop; next values are computed from state and btn_in.
module button_event_decoder #(
  parameter int                   TIMER_W   = 24,
  parameter logic [TIMER_W-1:0]   LONG_TIME = 24'd6000000,
  parameter logic [TIMER_W-1:0]   GAP_TIME  = 24'd3000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  button_event_decoder_if.slave   bus
);

  typedef enum logic [2:0] {
    ARM    = 3'd0,
    IDLE   = 3'd1,
    PRESS1 = 3'd2,
    GAP    = 3'd3,
    PRESS2 = 3'd4,
    HOLD   = 3'd5
  } state_t;

  // Terminal timer values: the timer counts 0..LAST inclusive.
  localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] LONG_LAST = LONG_TIME - TIMER_ONE;
  localparam logic [TIMER_W-1:0] GAP_LAST  = GAP_TIME - TIMER_ONE;

  state_t             state, state_next;
  logic [TIMER_W-1:0] timer, timer_next;
  logic               short_r, short_next;
  logic               long_r, long_next;
  logic               double_r, double_next;
  logic               holding_r, holding_next;
  logic               busy_r, busy_next;
  logic [7:0]         count_r, count_next;

  // Next-state, timer and pulse decode for the gesture FSM
  always_comb begin
    state_next  = state;
    timer_next  = timer;
    short_next  = 1'b0;
    long_next   = 1'b0;
    double_next = 1'b0;
    case (state)
      ARM: begin
        // A button held through reset must be released before anything counts
        if (!bus.btn_in) state_next = IDLE;
        else             state_next = ARM;
      end
      IDLE: begin
        if (bus.btn_in) begin
          state_next = PRESS1;
          timer_next = '0;
        end else begin
          state_next = IDLE;
        end
      end
      PRESS1: begin
        if (bus.btn_in) begin
          if (timer == LONG_LAST) begin
            long_next  = 1'b1;
            state_next = HOLD;
            timer_next = '0;
          end else begin
            timer_next = timer + TIMER_ONE;
          end
        end else begin
          state_next = GAP;
          timer_next = '0;
        end
      end
      GAP: begin
        if (bus.btn_in) begin
          state_next = PRESS2;
          timer_next = '0;
        end else if (timer == GAP_LAST) begin
          short_next = 1'b1;
          state_next = IDLE;
          timer_next = '0;
        end else begin
          timer_next = timer + TIMER_ONE;
        end
      end
      PRESS2: begin
        // Second press reports double whether released or held
        if (!bus.btn_in) begin
          double_next = 1'b1;
          state_next  = IDLE;
          timer_next  = '0;
        end else if (timer == LONG_LAST) begin
          double_next = 1'b1;
          state_next  = HOLD;
          timer_next  = '0;
        end else begin
          timer_next = timer + TIMER_ONE;
        end
      end
      HOLD: begin
        if (!bus.btn_in) state_next = IDLE;
        else             state_next = HOLD;
      end
      default: begin
        state_next = ARM;
        timer_next = '0;
      end
    endcase
  end

  // Status flags and counter follow the state being entered
  always_comb begin
    holding_next = (state_next == HOLD);
    busy_next    = !((state_next == IDLE) || (state_next == ARM));
    if (short_next || long_next || double_next) count_next = count_r + 8'd1;
    else                                        count_next = count_r;
  end

  // State, timer and registered outputs; reset abandons any gesture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ARM;
      timer     <= '0;
      short_r   <= 1'b0;
      long_r    <= 1'b0;
      double_r  <= 1'b0;
      holding_r <= 1'b0;
      busy_r    <= 1'b0;
      count_r   <= 8'd0;
    end else begin
      state     <= state_next;
      timer     <= timer_next;
      short_r   <= short_next;
      long_r    <= long_next;
      double_r  <= double_next;
      holding_r <= holding_next;
      busy_r    <= busy_next;
      count_r   <= count_next;
    end
  end

  assign bus.short_press  = short_r;
  assign bus.long_press   = long_r;
  assign bus.double_press = double_r;
  assign bus.holding      = holding_r;
  assign bus.busy         = busy_r;
  assign bus.event_count  = count_r;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with LONG_TIME=8, GAP_TIME=4.
// Expected pulses (edge index + kind) are queued when a gesture is driven
// and matched against the DUT pulses as they appear.
module tb_button_event_decoder;

  localparam int LT = 8;
  localparam int GT = 4;
  localparam logic [2:0] K_SHORT  = 3'b001;
  localparam logic [2:0] K_LONG   = 3'b010;
  localparam logic [2:0] K_DOUBLE = 3'b100;

  logic clk;
  logic rst_n;
  button_event_decoder_if bus();

  button_event_decoder #(
    .TIMER_W  (24),
    .LONG_TIME(24'd8),
    .GAP_TIME (24'd4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         passed = 0;
  int         total  = 0;
  int         cyc    = 0;
  int         exp_cyc[$];
  logic [2:0] exp_kind[$];
  logic [7:0] exp_count = 8'd0;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic push(input int c, input logic [2:0] k);
    exp_cyc.push_back(c);
    exp_kind.push_back(k);
  endtask

  // One clock: drive btn, let the edge happen, then score the outputs
  task automatic tick(input logic b);
    logic [2:0] pulses;
    int         c;
    logic [2:0] k;
    bus.btn_in = b;
    @(posedge clk);
    #1;
    cyc++;
    pulses = {bus.double_press, bus.long_press, bus.short_press};
    if (pulses != 3'b000) begin
      check("one_pulse", $countones(pulses), 1);
      if (exp_cyc.size() == 0) begin
        check("unexpected_pulse", int'(pulses), 0);
      end else begin
        c = exp_cyc.pop_front();
        k = exp_kind.pop_front();
        check("pulse_edge", cyc, c);
        check("pulse_kind", int'(pulses), int'(k));
        exp_count = exp_count + 8'd1;
      end
    end else if (exp_cyc.size() != 0 && exp_cyc[0] <= cyc) begin
      check("missing_pulse", cyc, exp_cyc[0]);
      void'(exp_cyc.pop_front());
      void'(exp_kind.pop_front());
    end
    check("event_count", int'(bus.event_count), int'(exp_count));
  endtask

  task automatic do_reset(input logic b, input int n);
    rst_n = 1'b0;
    exp_cyc.delete();
    exp_kind.delete();
    exp_count = 8'd0;
    repeat (n) tick(b);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_holding", int'(bus.holding), 0);
    check("rst_count", int'(bus.event_count), 0);
    rst_n = 1'b1;
  endtask

  initial begin
    int p;
    rst_n      = 1'b0;
    bus.btn_in = 1'b1;

    // Button held through reset: no event, never busy
    do_reset(1'b1, 2);
    for (int i = 0; i < 20; i++) begin
      tick(1'b1);
      check("arm_busy", int'(bus.busy), 0);
    end
    tick(1'b0);
    check("arm_rel_busy", int'(bus.busy), 0);
    // Short press: 3 high, pulse GAP_TIME edges after the release edge
    p = cyc + 1;
    push(p + 3 + GT, K_SHORT);
    tick(1'b1);
    check("short_busy", int'(bus.busy), 1);
    tick(1'b1);
    tick(1'b1);
    repeat (GT + 1) tick(1'b0);
    check("short_count", int'(bus.event_count), 1);
    check("short_idle", int'(bus.busy), 0);
    // New gesture right after the pulse
    p = cyc + 1;
    push(p + LT, K_LONG);
    repeat (LT + 1) tick(1'b1);
    check("b2b_holding", int'(bus.holding), 1);
    tick(1'b0);
    check("b2b_release", int'(bus.holding), 0);
    check("b2b_count", int'(bus.event_count), 2);

    // Long press held 20 cycles
    do_reset(1'b0, 2);
    tick(1'b0);
    p = cyc + 1;
    push(p + LT, K_LONG);
    for (int i = 0; i < 20; i++) begin
      tick(1'b1);
      check("long_holding", int'(bus.holding), (i >= LT) ? 1 : 0);
    end
    tick(1'b0);
    check("long_rel_holding", int'(bus.holding), 0);
    check("long_rel_busy", int'(bus.busy), 0);
    repeat (8) tick(1'b0);
    check("long_count", int'(bus.event_count), 1);

    // Double press, second press released
    do_reset(1'b0, 2);
    tick(1'b0);
    p = cyc + 1;
    push(p + 7, K_DOUBLE);
    repeat (3) tick(1'b1);
    repeat (2) tick(1'b0);
    repeat (2) tick(1'b1);
    repeat (8) tick(1'b0);
    check("double_count", int'(bus.event_count), 1);

    // Double press, second press held
    do_reset(1'b0, 2);
    tick(1'b0);
    p = cyc + 1;
    push(p + 5 + LT, K_DOUBLE);
    repeat (3) tick(1'b1);
    repeat (2) tick(1'b0);
    for (int i = 0; i < 20; i++) begin
      tick(1'b1);
      check("dhold_holding", int'(bus.holding), (i >= LT) ? 1 : 0);
    end
    tick(1'b0);
    check("dhold_release", int'(bus.holding), 0);
    repeat (8) tick(1'b0);
    check("dhold_count", int'(bus.event_count), 1);

    // Reset in the middle of GAP discards the gesture
    do_reset(1'b0, 2);
    tick(1'b0);
    repeat (3) tick(1'b1);
    tick(1'b0);
    tick(1'b0);
    check("gap_busy", int'(bus.busy), 1);
    do_reset(1'b0, 1);
    repeat (10) begin
      tick(1'b0);
      check("post_rst_busy", int'(bus.busy), 0);
    end
    check("post_rst_count", int'(bus.event_count), 0);
    // Decoder is back in IDLE: a fresh short press is recognised
    p = cyc + 1;
    push(p + 2 + GT, K_SHORT);
    repeat (2) tick(1'b1);
    repeat (GT + 2) tick(1'b0);
    check("post_rst_short", int'(bus.event_count), 1);

    // 257 long presses: counter wraps to 1
    do_reset(1'b0, 2);
    tick(1'b0);
    for (int n = 0; n < 257; n++) begin
      p = cyc + 1;
      push(p + LT, K_LONG);
      repeat (LT + 1) tick(1'b1);
      tick(1'b0);
    end
    repeat (4) tick(1'b0);
    check("wrap_count", int'(bus.event_count), 1);
    check("queue_empty", exp_cyc.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
